// File: rtl/neo_pkg.sv
// neo_pkg: shared state encoding, default sizes and result width for the NEO engine
package neo_pkg;
  localparam int N_DEF = 16;
  localparam int M_DEF = 32;
  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
  function automatic int res_w(input int n);
    return 2 * n + 1;
  endfunction
endpackage

// File: rtl/neo_datapath.sv
// neo_datapath: sample window and psi[n] = x[n]^2 - x[n-1]*x[n+1] arithmetic
module neo_datapath import neo_pkg::*; #(
  parameter int N = N_DEF,
  parameter logic signed [res_w(N)-1:0] THRESH = '0
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        clr,
  input  logic                        shift,
  input  logic signed [N-1:0]         rdata,
  output logic signed [res_w(N)-1:0]  neo_out,
  output logic                        spike,
  output logic                        fire
);
  localparam int W = res_w(N);
  // the incoming sample is x[n+1]; w0/w1 hold x[n]/x[n-1]
  logic signed [N-1:0]   w0, w1;
  logic [1:0]            cnt;
  logic signed [2*N-1:0] sq, cr;
  logic signed [W-1:0]   psi;
  assign sq   = (2*N)'(w0) * (2*N)'(w0);
  assign cr   = (2*N)'(w1) * (2*N)'(rdata);
  assign psi  = W'(sq) - W'(cr);
  assign fire = shift && cnt == 2'd2;
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      w0      <= '0;
      w1      <= '0;
      cnt     <= '0;
      neo_out <= '0;
      spike   <= 1'b0;
    end else if (clr) begin
      w0  <= '0;
      w1  <= '0;
      cnt <= '0;
    end else if (shift) begin
      w0  <= rdata;
      w1  <= w0;
      cnt <= cnt == 2'd2 ? cnt : cnt + 2'd1;
      if (fire) begin
        neo_out <= psi;
        spike   <= psi > THRESH;
      end
    end
  end
endmodule

// File: rtl/neo_engine.sv
// neo_engine: frame sequencer streaming M samples from memory through the NEO datapath
module neo_engine import neo_pkg::*; #(
  parameter int N = N_DEF,
  parameter int M = M_DEF,
  parameter logic signed [res_w(N)-1:0] THRESH = '0
) (
  input  logic                        Clk,
  input  logic                        reset,
  input  logic                        start,
  output logic [$clog2(M)-1:0]        raddr,
  input  logic signed [N-1:0]         rdata,
  output logic signed [res_w(N)-1:0]  neo_out,
  output logic                        neo_valid,
  input  logic                        neo_ready,
  output logic                        spike,
  output logic                        busy,
  output logic                        done
);
  localparam int AW = $clog2(M);
  state_t state;
  logic   rd_pending, issue, fire, spike_r, clr, drain_end;
  // a read is only issued when its result can never overwrite an unaccepted one
  assign issue     = state == FETCH && !rd_pending && (!neo_valid || neo_ready);
  assign drain_end = state == DRAIN && !rd_pending && neo_valid && neo_ready;
  assign clr       = state == IDLE && start;
  assign spike     = spike_r && neo_valid;
  neo_datapath #(.N(N), .THRESH(THRESH)) u_dp (
    .Clk     (Clk),
    .reset   (reset),
    .clr     (clr),
    .shift   (rd_pending),
    .rdata   (rdata),
    .neo_out (neo_out),
    .spike   (spike_r),
    .fire    (fire)
  );
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      raddr      <= '0;
      rd_pending <= 1'b0;
      neo_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      rd_pending <= issue;
      neo_valid  <= fire || (neo_valid && !neo_ready);
      done       <= drain_end;
      case (state)
        IDLE: if (start) begin
          state <= FETCH;
          raddr <= '0;
          busy  <= 1'b1;
        end
        FETCH: if (issue) begin
          if (raddr == AW'(M - 1)) state <= DRAIN;
          else raddr <= raddr + AW'(1);
        end
        DRAIN: if (drain_end) state <= DONE;
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_neo_engine.sv
// tb_neo_engine: directed frames with random data/backpressure against an arithmetic psi model
module tb_neo_engine;
  localparam int N = 16;
  localparam int M = 32;
  localparam logic signed [32:0] TH = 33'sd1000;
  logic Clk = 1'b0, reset = 1'b0, start = 1'b0, neo_ready = 1'b0;
  logic [4:0] raddr;
  logic signed [15:0] rdata = '0;
  logic signed [32:0] neo_out;
  logic neo_valid, spike, busy, done;
  logic signed [15:0] mem [M];
  int tests = 0, fails = 0;

  always #5 Clk = ~Clk;
  always @(posedge Clk) rdata <= mem[raddr];

  neo_engine #(.N(N), .M(M), .THRESH(TH)) dut (
    .Clk(Clk), .reset(reset), .start(start), .raddr(raddr), .rdata(rdata),
    .neo_out(neo_out), .neo_valid(neo_valid), .neo_ready(neo_ready),
    .spike(spike), .busy(busy), .done(done)
  );

  task automatic chk(input string tag, input longint obs, input longint exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint psi(input int n);
    longint a, b, c;
    a = mem[n-1];
    b = mem[n];
    c = mem[n+1];
    return b * b - a * c;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, ":raddr"}, raddr, 0);
    chk({tag, ":neo_out"}, neo_out, 0);
    chk({tag, ":valid"}, neo_valid, 0);
    chk({tag, ":spike"}, spike, 0);
    chk({tag, ":busy"}, busy, 0);
    chk({tag, ":done"}, done, 0);
  endtask

  // mode: 0 ready=1, 1 random ready, 2 ready low 10 cycles after first result, 3 ready=1 + start while busy
  task automatic run_frame(input string nm, input int mode, input int abort_at,
                           input int spec_n, input longint spec_v);
    int cyc, idx, dones, first, stall_left;
    bit held;
    longint h_out;
    logic [4:0] h_addr;
    logic h_sp;
    idx = 1; dones = 0; first = 0; held = 0; stall_left = 10;
    start = 1'b1; neo_ready = 1'b1;
    @(negedge Clk);
    cyc = 0;
    while (cyc < 3000) begin
      if (held) begin
        chk({nm, ":hold_out"}, neo_out, h_out);
        chk({nm, ":hold_addr"}, raddr, h_addr);
        chk({nm, ":hold_spike"}, spike, h_sp);
      end
      if (first == 0 && neo_valid) first = cyc;
      case (mode)
        1: neo_ready = $urandom_range(0, 3) != 0;
        2: begin
          neo_ready = !(first != 0 && stall_left > 0);
          if (!neo_ready) stall_left--;
        end
        default: neo_ready = 1'b1;
      endcase
      start = mode == 3 && cyc == 20;
      if (neo_valid && neo_ready) begin
        chk({nm, ":psi"}, neo_out, psi(idx));
        chk({nm, ":spike"}, spike, psi(idx) > TH);
        if (idx == spec_n) chk({nm, ":spec_psi"}, neo_out, spec_v);
        idx++;
        if (idx - 1 == abort_at) return;
      end
      held = neo_valid && !neo_ready;
      h_out = neo_out; h_addr = raddr; h_sp = spike;
      if (done) begin
        dones++;
        @(negedge Clk);
        chk({nm, ":done_width"}, done, 0);
        chk({nm, ":busy_end"}, busy, 0);
        break;
      end
      @(negedge Clk);
      cyc++;
    end
    chk({nm, ":count"}, idx - 1, M - 2);
    chk({nm, ":dones"}, dones, 1);
    if (mode == 0) chk({nm, ":latency"}, first, 6);
  endtask

  initial begin
    for (int k = 0; k < M; k++) mem[k] = 16'(k);
    repeat (3) @(negedge Clk);
    chk_idle("reset");
    reset = 1'b1;
    repeat (3) @(negedge Clk);
    chk("post_reset_idle", busy, 0);

    run_frame("ramp", 0, 0, 15, 1);

    for (int k = 0; k < M; k++) mem[k] = '0;
    mem[5] = 16'sd300;
    run_frame("impulse", 0, 0, 5, 90000);

    for (int k = 0; k < M; k++) mem[k] = 16'($urandom);
    mem[0] = -16'sd32768; mem[1] = '0; mem[2] = 16'sd32767;
    run_frame("extreme", 1, 0, 1, 64'sd1073709056);

    for (int k = 0; k < M; k++) mem[k] = -16'sd32768;
    run_frame("allneg", 0, 0, 10, 0);

    for (int k = 0; k < M; k++) mem[k] = 16'($urandom);
    run_frame("stall", 2, 0, 0, 0);

    for (int k = 0; k < M; k++) mem[k] = 16'($urandom);
    run_frame("abort", 0, 10, 0, 0);
    #2 reset = 1'b0;
    #1 chk_idle("mid_reset");
    @(negedge Clk);
    reset = 1'b1;
    @(negedge Clk);
    chk("after_mid_reset_busy", busy, 0);
    run_frame("restart", 1, 0, 0, 0);

    for (int k = 0; k < M; k++) mem[k] = 16'($urandom);
    run_frame("busy_start", 3, 0, 0, 0);

    repeat (3) @(negedge Clk);
    chk("final_idle", busy, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
